his_peak_reader: RTL and testbench
==================================

Name: his_peak_reader

Overview:
- Read-side counterpart of the histogram builder. After a build completes, scans every pixel's histogram in the dual-port RAM through port b, finds the peak bin per pixel and reports it.
- Optionally clears each bin to zero through port a as it is read, so the RAM is ready for the next acquisition.
- Sits between the histogram RAM and the ToF result path. It is started by the builder's done pulse.

Parameters:
BIN_NUM, 16, bins per pixel histogram (power of two)
PIX_NUM, 4, pixels stored per RAM
BIN_W, 4, bin index width (log2 BIN_NUM)
PIX_W, 2, pixel index width (log2 PIX_NUM)
RAM_ADDR, 6, RAM address width (BIN_W+PIX_W)
CNT_W, 8, bin count width
CLEAR_EN, 1, 1 = write zero to each bin after reading it

Ports:
clk  in  1  clock
res  in  1  asynchronous reset, active-high
start  in  1  single-cycle start pulse (builder done)
counts  in  CNT_W  RAM port b read data, valid the cycle after a read is issued
raddr  out  RAM_ADDR  port b address
rEnable  out  1  port b read enable, active-high
readFlag  out  1  port b memory enable, active-high
waddr  out  RAM_ADDR  port a address
wEnable  out  1  port a write enable, active-high
writeFlag  out  1  port a memory enable, active-high
newCounts  out  CNT_W  port a write data (always 0)
peakPixel  out  PIX_W  pixel index of the current result
peakBin  out  BIN_W  bin index holding the maximum count
peakCount  out  CNT_W  maximum count value
peakValid  out  1  one-cycle pulse, result fields valid
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse coinciding with the last peakValid

Behaviour:
- Reset (asynchronous, res=1):
  - All outputs go to 0. FSM goes to IDLE. Running max, index and address counters clear.
  - Reset mid-scan discards partial results and emits no peakValid or done.
- FSM states:
  - IDLE: start=1 -> ISSUE.
  - ISSUE: issue one read per cycle. Leave after address N-1 (N=BIN_NUM*PIX_NUM) -> DRAIN.
  - DRAIN: one cycle to consume the last read data -> FLUSH.
  - FLUSH: emit the last result together with done -> IDLE.
- start while busy=1 is ignored. busy=1 in ISSUE, DRAIN and FLUSH.
- Read issue: let c be the cycle counter, c=0 on the first ISSUE cycle.
  - In cycle c (c<N): raddr=c, rEnable=readFlag=1. Address mapping is pixel*BIN_NUM+bin.
  - rEnable and readFlag are 0 otherwise.
- Data: counts for address k is sampled in cycle k+1. A delayed address register (k) tracks which bin is being evaluated.
- Max search:
  - The first bin of each pixel loads the running max unconditionally (count, bin).
  - Later bins replace it only if counts > max (strict), so ties keep the lowest bin.
- Result timing:
  - When the data of bin BIN_NUM-1 of pixel p is evaluated (cycle (p+1)*BIN_NUM), the final max includes that bin.
  - peakPixel, peakBin and peakCount are registered and peakValid=1 in cycle (p+1)*BIN_NUM+1.
  - Result fields hold until the next peakValid.
  - The running max for pixel p+1 starts in that same data cycle with no bubble.
- Done: done=1 in cycle N+1, together with the last peakValid. busy drops in the following cycle. Total scan latency from the first issue is N+2 cycles.
- Clear (CLEAR_EN=1):
  - In data cycle k+1: waddr=k, wEnable=writeFlag=1, newCounts=0.
  - Port a (write k) and port b (read k+1) never collide.
- Clear (CLEAR_EN=0): wEnable and writeFlag stay 0.
- Width rules:
  - Comparison is unsigned over CNT_W. A saturated count (all ones) is a legal maximum.
  - Address counter is RAM_ADDR wide; bin = low BIN_W bits, pixel = high PIX_W bits. No wrap inside a scan.
- Edge cases:
  - All-zero histogram -> peakBin=0, peakCount=0, peakValid still pulses.
  - start asserted in the same cycle done pulses -> ignored, since busy is still 1.

Decomposition:
- Shared package (parametersSiFH.vh):
  - BIN_NUM_PER_HIS, PIXEL_NUM_PER_RAM, RAM_ADDR, peakMax (count width), Nb (bin width).
  - Derived pixel width.
  - FSM state encodings.
- One natural sub-module: his_max_tracker. Holds the running max count and bin, with inputs load_first, valid_in, count, bin and outputs max_count, max_bin. Strict-greater update.

Test Plan:
- Single pixel ramp: bin b holds count b for pixel 0, start pulse -> peakPixel=0, peakBin=15, peakCount=15, peakValid in cycle 17 after the first issue.
- Tie: pixel 1 has count 9 in bins 3 and 11, all others 2 -> peakBin=3, peakCount=9.
- Full scan, 4 pixels, peaks at bins 0, 7, 15, 8 with counts 255, 40, 1, 100 -> four peakValid pulses in cycles 17, 33, 49, 65; done=1 in cycle 65; busy low in cycle 66.
- Clear check (CLEAR_EN=1): after the scan, read back all 64 addresses -> all 0. Monitor that waddr never equals raddr in the same cycle.
- Reset mid-scan: assert res in cycle 20 -> all outputs 0 immediately. A new start after release produces a complete correct scan with no leftover peakValid.
- start re-pulsed at cycles 5 and 65 while busy -> ignored; exactly 4 peakValid and 1 done.

Source files
------------

// File: rtl/his_peak_reader_pkg.sv
// Shared sizing and FSM encoding for the histogram peak reader.
package his_peak_reader_pkg;
   localparam int BIN_NUM_PER_HIS   = 16;
   localparam int PIXEL_NUM_PER_RAM = 4;
   localparam int RAM_ADDR          = 6;
   localparam int peakMax           = 8;
   localparam int Nb                = 4;
   localparam int PIX_W             = $clog2(PIXEL_NUM_PER_RAM);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      FLUSH = 2'd3
   } state_t;
endpackage

// File: rtl/his_peak_reader_max_tracker.sv
// Running maximum over one pixel's bins; outputs already include the current input,
// so the last bin of a pixel is visible in the same cycle it is evaluated.
module his_max_tracker #(
   parameter int CNT_W = 8,
   parameter int BIN_W = 4
) (
   input  logic             clk,
   input  logic             res,
   input  logic             load_first,
   input  logic             valid_in,
   input  logic [CNT_W-1:0] count,
   input  logic [BIN_W-1:0] bin,
   output logic [CNT_W-1:0] max_count,
   output logic [BIN_W-1:0] max_bin
);
   logic [CNT_W-1:0] cur_count;
   logic [BIN_W-1:0] cur_bin;

   // Strict compare keeps the lowest bin on ties.
   always_comb begin
      max_count = cur_count;
      max_bin   = cur_bin;
      if (valid_in && (load_first || count > cur_count)) begin
         max_count = count;
         max_bin   = bin;
      end
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         cur_count <= '0;
         cur_bin   <= '0;
      end else begin
         cur_count <= max_count;
         cur_bin   <= max_bin;
      end
   end
endmodule

// File: rtl/his_peak_reader.sv
// Scans every pixel histogram through RAM port b, reports the peak bin per pixel,
// and optionally zeroes each bin through port a one cycle behind the read.
module his_peak_reader
   import his_peak_reader_pkg::*;
#(
   parameter int BIN_NUM  = BIN_NUM_PER_HIS,
   parameter int PIX_NUM  = PIXEL_NUM_PER_RAM,
   parameter int BIN_W    = Nb,
   parameter int PIX_W    = his_peak_reader_pkg::PIX_W,
   parameter int RAM_ADDR = his_peak_reader_pkg::RAM_ADDR,
   parameter int CNT_W    = peakMax,
   parameter bit CLEAR_EN = 1'b1
) (
   input  logic                clk,
   input  logic                res,
   input  logic                start,
   input  logic [CNT_W-1:0]    counts,
   output logic [RAM_ADDR-1:0] raddr,
   output logic                rEnable,
   output logic                readFlag,
   output logic [RAM_ADDR-1:0] waddr,
   output logic                wEnable,
   output logic                writeFlag,
   output logic [CNT_W-1:0]    newCounts,
   output logic [PIX_W-1:0]    peakPixel,
   output logic [BIN_W-1:0]    peakBin,
   output logic [CNT_W-1:0]    peakCount,
   output logic                peakValid,
   output logic                busy,
   output logic                done
);
   localparam int                N    = BIN_NUM * PIX_NUM;
   localparam logic [RAM_ADDR-1:0] LAST = RAM_ADDR'(N - 1);

   state_t              state, nxt;
   logic [RAM_ADDR-1:0] addr_cnt, rd_addr;
   logic                rd_vld, issue, first_bin, last_bin;
   logic [CNT_W-1:0]    max_count;
   logic [BIN_W-1:0]    max_bin;

   assign issue = (state == ISSUE);

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state    <= IDLE;
         addr_cnt <= '0;
      end else begin
         state    <= nxt;
         addr_cnt <= issue ? addr_cnt + 1'b1 : '0;
      end
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (start) nxt = ISSUE;
         ISSUE:   if (addr_cnt == LAST) nxt = DRAIN;
         DRAIN:   nxt = FLUSH;
         FLUSH:   nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   assign raddr    = issue ? addr_cnt : '0;
   assign rEnable  = issue;
   assign readFlag = issue;
   assign busy     = (state != IDLE);
   assign done     = (state == FLUSH);

   // Delayed address names the bin whose data arrives on counts this cycle.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         rd_vld  <= 1'b0;
         rd_addr <= '0;
      end else begin
         rd_vld  <= issue;
         rd_addr <= addr_cnt;
      end
   end

   assign first_bin = rd_vld && (rd_addr[BIN_W-1:0] == '0);
   assign last_bin  = rd_vld && (&rd_addr[BIN_W-1:0]);

   his_max_tracker #(.CNT_W(CNT_W), .BIN_W(BIN_W)) u_trk (
      .clk        (clk),
      .res        (res),
      .load_first (first_bin),
      .valid_in   (rd_vld),
      .count      (counts),
      .bin        (rd_addr[BIN_W-1:0]),
      .max_count  (max_count),
      .max_bin    (max_bin)
   );

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         peakValid <= 1'b0;
         peakPixel <= '0;
         peakBin   <= '0;
         peakCount <= '0;
      end else begin
         peakValid <= last_bin;
         if (last_bin) begin
            peakPixel <= rd_addr[RAM_ADDR-1 -: PIX_W];
            peakBin   <= max_bin;
            peakCount <= max_count;
         end
      end
   end

   // Clearing address k while reading k+1 keeps the two ports apart.
   assign wEnable   = CLEAR_EN && rd_vld;
   assign writeFlag = wEnable;
   assign waddr     = wEnable ? rd_addr : '0;
   assign newCounts = '0;
endmodule

// File: tb/tb_his_peak_reader.sv
// Directed bench for his_peak_reader with a behavioural dual-port RAM.
module tb_his_peak_reader;
   logic       clk = 1'b0;
   logic       res, start;
   logic [7:0] counts = '0;
   logic [5:0] raddr, waddr;
   logic       rEnable, readFlag, wEnable, writeFlag, peakValid, busy, done;
   logic [7:0] newCounts, peakCount;
   logic [1:0] peakPixel;
   logic [3:0] peakBin;

   logic [7:0] mem [64];
   int cyc = 0, base = 0, checks = 0, errors = 0, coll = 0;
   int pv_n, done_n, done_c, b65, b66, nz, n_before;
   int pv_c [8], pv_p [8], pv_b [8], pv_k [8];
   int eb [4], ec [4];

   his_peak_reader dut (
      .clk(clk), .res(res), .start(start), .counts(counts),
      .raddr(raddr), .rEnable(rEnable), .readFlag(readFlag),
      .waddr(waddr), .wEnable(wEnable), .writeFlag(writeFlag),
      .newCounts(newCounts), .peakPixel(peakPixel), .peakBin(peakBin),
      .peakCount(peakCount), .peakValid(peakValid), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (rEnable && readFlag) counts <= mem[raddr];
      if (wEnable && writeFlag) mem[waddr] <= newCounts;
   end

   always @(negedge clk) begin
      if (!res) begin
         if (peakValid && pv_n < 8) begin
            pv_c[pv_n] = cyc - base;
            pv_p[pv_n] = int'(peakPixel);
            pv_b[pv_n] = int'(peakBin);
            pv_k[pv_n] = int'(peakCount);
            pv_n++;
         end
         if (done) begin
            done_c = cyc - base;
            done_n++;
         end
         if (wEnable && rEnable && waddr == raddr) coll++;
      end
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
      end
   endtask

   task automatic fill_a();
      for (int b = 0; b < 16; b++) begin
         mem[b]      = 8'(b);
         mem[16 + b] = (b == 3 || b == 11) ? 8'd9 : 8'd2;
         mem[32 + b] = 8'd0;
         mem[48 + b] = (b == 5 || b == 14) ? 8'd255 : 8'd254;
      end
      eb = '{15, 3, 0, 5};
      ec = '{15, 9, 0, 255};
   endtask

   task automatic fill_b();
      for (int b = 0; b < 16; b++) begin
         mem[b]      = (b == 0) ? 8'd255 : 8'(b * 10);
         mem[16 + b] = (b == 7) ? 8'd40 : 8'(b);
         mem[32 + b] = (b == 15) ? 8'd1 : 8'd0;
         mem[48 + b] = (b == 8 || b == 12) ? 8'd100 : 8'd99;
      end
      eb = '{0, 7, 15, 8};
      ec = '{255, 40, 1, 100};
   endtask

   task automatic kick();
      pv_n = 0; done_n = 0; done_c = -1;
      @(negedge clk);
      start = 1'b1;
      base  = cyc + 1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Start on return is at the negedge of cycle 0; runs to cycle 70.
   task automatic scan(input bit repulse);
      b65 = 0; b66 = 1;
      kick();
      for (int c = 1; c <= 70; c++) begin
         @(negedge clk);
         if (c == 65) b65 = int'(busy);
         if (c == 66) b66 = int'(busy);
         start = repulse && (c == 5 || c == 65);
      end
      start = 1'b0;
   endtask

   task automatic check_scan(input string tag);
      chk({tag, "_pv_n"}, pv_n, 4);
      for (int p = 0; p < 4; p++) begin
         if (p < pv_n) begin
            chk($sformatf("%s_pv%0d_cyc", tag, p), pv_c[p], 17 + 16 * p);
            chk($sformatf("%s_pv%0d_pix", tag, p), pv_p[p], p);
            chk($sformatf("%s_pv%0d_bin", tag, p), pv_b[p], eb[p]);
            chk($sformatf("%s_pv%0d_cnt", tag, p), pv_k[p], ec[p]);
         end
      end
      chk({tag, "_done_n"}, done_n, 1);
      chk({tag, "_done_cyc"}, done_c, 65);
      chk({tag, "_busy65"}, b65, 1);
      chk({tag, "_busy66"}, b66, 0);
   endtask

   task automatic check_clear(input string tag);
      nz = 0;
      for (int a = 0; a < 64; a++) if (mem[a] != 8'd0) nz++;
      chk(tag, nz, 0);
   endtask

   initial begin
      res = 1'b1; start = 1'b0;
      pv_n = 0; done_n = 0; done_c = -1;
      repeat (3) @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_ren", int'(rEnable), 0);
      chk("rst_wen", int'(wEnable), 0);
      chk("rst_pv", int'(peakValid), 0);
      chk("rst_cnt", int'(peakCount), 0);
      res = 1'b0;
      repeat (2) @(negedge clk);

      fill_a();
      scan(1'b1);
      check_scan("a");
      check_clear("a_clear");

      fill_b();
      scan(1'b0);
      check_scan("b");
      check_clear("b_clear");
      chk("port_collision", coll, 0);

      fill_a();
      kick();
      repeat (20) @(negedge clk);
      chk("mid_pv_before", pv_n, 1);
      res = 1'b1;
      #1;
      chk("mid_busy", int'(busy), 0);
      chk("mid_ren", int'(rEnable), 0);
      chk("mid_raddr", int'(raddr), 0);
      chk("mid_wen", int'(wEnable), 0);
      chk("mid_pv", int'(peakValid), 0);
      chk("mid_pk", int'({peakPixel, peakBin, peakCount}), 0);
      chk("mid_done", int'(done), 0);
      n_before = pv_n;
      repeat (3) @(negedge clk);
      res = 1'b0;
      repeat (80) @(negedge clk);
      chk("post_rst_pv", pv_n, n_before);
      chk("post_rst_done", done_n, 0);

      fill_a();
      scan(1'b0);
      check_scan("r");
      check_clear("r_clear");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
